// File: rtl/dht11_responder.sv
`timescale 1ns/1ps
// dht11_responder: device end of the DHT11 single-wire protocol. Watches the
// open-drain DATA line for a host start pulse and answers with the response
// preamble followed by a 40-bit frame loaded by the CPU over Avalon-MM.
module dht11_responder #(
  parameter int unsigned T_START_MIN = 900000,
  parameter int unsigned T_WAIT      = 1500,
  parameter int unsigned T_RESP_LOW  = 4000,
  parameter int unsigned T_RESP_HIGH = 4000,
  parameter int unsigned T_BIT_LOW   = 2500,
  parameter int unsigned T_ZERO_HIGH = 1300,
  parameter int unsigned T_ONE_HIGH  = 3500,
  parameter int unsigned T_END_LOW   = 2500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  inout  wire         data_pin
);

  // Counter must hold the largest phase length and the start threshold.
  localparam int unsigned M0 = (T_START_MIN > T_WAIT)      ? T_START_MIN : T_WAIT;
  localparam int unsigned M1 = (M0 > T_RESP_LOW)           ? M0 : T_RESP_LOW;
  localparam int unsigned M2 = (M1 > T_RESP_HIGH)          ? M1 : T_RESP_HIGH;
  localparam int unsigned M3 = (M2 > T_BIT_LOW)            ? M2 : T_BIT_LOW;
  localparam int unsigned M4 = (M3 > T_ZERO_HIGH)          ? M3 : T_ZERO_HIGH;
  localparam int unsigned M5 = (M4 > T_ONE_HIGH)           ? M4 : T_ONE_HIGH;
  localparam int unsigned T_MAX = (M5 > T_END_LOW)         ? M5 : T_END_LOW;
  localparam int unsigned CNT_W = (T_MAX < 2) ? 1 : $clog2(T_MAX + 1);
  localparam int unsigned BIT_W = 6;
  localparam int unsigned FRAME_W = 40;

  localparam logic [CNT_W-1:0] START_MIN  = CNT_W'(T_START_MIN);
  localparam logic [CNT_W-1:0] LAST_WAIT  = CNT_W'(T_WAIT - 1);
  localparam logic [CNT_W-1:0] LAST_RLOW  = CNT_W'(T_RESP_LOW - 1);
  localparam logic [CNT_W-1:0] LAST_RHIGH = CNT_W'(T_RESP_HIGH - 1);
  localparam logic [CNT_W-1:0] LAST_BLOW  = CNT_W'(T_BIT_LOW - 1);
  localparam logic [CNT_W-1:0] LAST_ZERO  = CNT_W'(T_ZERO_HIGH - 1);
  localparam logic [CNT_W-1:0] LAST_ONE   = CNT_W'(T_ONE_HIGH - 1);
  localparam logic [CNT_W-1:0] LAST_ELOW  = CNT_W'(T_END_LOW - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOST_LOW,
    S_WAIT,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_END_LOW
  } state_t;

  state_t state, next_state;

  logic [7:0]         hum_int, hum_dec, temp_int, temp_dec, ctrl;
  logic [7:0]         frame_count;
  logic [7:0]         checksum;
  logic [FRAME_W-1:0] shadow;
  logic [BIT_W-1:0]   bit_idx, bit_idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   high_last;
  logic [1:0]         pin_sync;
  logic               pin_s;
  logic               enable;
  logic               busy;
  logic               cur_bit;
  logic               load_shadow;
  logic               frame_done;
  logic               drive_low, drive_nxt;
  logic               unused_wdata;

  assign enable       = ctrl[0];
  assign busy         = (state != S_IDLE);
  assign pin_s        = pin_sync[1];
  assign checksum     = hum_int + hum_dec + temp_int + temp_dec;
  assign cur_bit      = shadow[LAST_BIT - bit_idx];
  assign high_last    = cur_bit ? LAST_ONE : LAST_ZERO;
  assign unused_wdata = ^writedata[31:8];

  // Open-drain pad: only ever pulls low, otherwise released.
  assign data_pin = drive_low ? 1'b0 : 1'bz;

  // Two-flop synchronizer on the shared line; idles high like the pulled-up wire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_sync <= 2'b11;
    end else begin
      pin_sync <= {pin_sync[0], data_pin};
    end
  end

  // CPU-visible register file; only the low byte of a write is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hum_int  <= '0;
      hum_dec  <= '0;
      temp_int <= '0;
      temp_dec <= '0;
      ctrl     <= '0;
    end else if (write) begin
      case (address)
        4'd0:    hum_int  <= writedata[7:0];
        4'd1:    hum_dec  <= writedata[7:0];
        4'd2:    temp_int <= writedata[7:0];
        4'd3:    temp_dec <= writedata[7:0];
        4'd4:    ctrl     <= writedata[7:0];
        default: ;
      endcase
    end
  end

  // Combinational read mux; zero when not reading or for unmapped addresses.
  always_comb begin
    readdata = '0;
    if (read) begin
      case (address)
        4'd0:    readdata = {24'd0, hum_int};
        4'd1:    readdata = {24'd0, hum_dec};
        4'd2:    readdata = {24'd0, temp_int};
        4'd3:    readdata = {24'd0, temp_dec};
        4'd4:    readdata = {24'd0, ctrl};
        4'd5:    readdata = {16'd0, frame_count, 7'd0, busy};
        default: readdata = '0;
      endcase
    end
  end

  // Next-state, phase counter and pad-drive decode.
  always_comb begin
    next_state  = state;
    cnt_nxt     = cnt + CNT_W'(1);
    bit_idx_nxt = bit_idx;
    load_shadow = 1'b0;
    frame_done  = 1'b0;
    drive_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (enable && !pin_s) next_state = S_HOST_LOW;
      end
      S_HOST_LOW: begin
        if (pin_s) begin
          if (cnt >= START_MIN) begin
            load_shadow = 1'b1;
            next_state  = S_WAIT;
          end else begin
            next_state = S_IDLE;
          end
        end else if (cnt >= START_MIN) begin
          cnt_nxt = cnt;
        end
      end
      S_WAIT: begin
        if (cnt == LAST_WAIT) next_state = S_RESP_LOW;
      end
      S_RESP_LOW: begin
        if (cnt == LAST_RLOW) next_state = S_RESP_HIGH;
      end
      S_RESP_HIGH: begin
        if (cnt == LAST_RHIGH) begin
          next_state  = S_BIT_LOW;
          bit_idx_nxt = '0;
        end
      end
      S_BIT_LOW: begin
        if (cnt == LAST_BLOW) next_state = S_BIT_HIGH;
      end
      S_BIT_HIGH: begin
        if (cnt == high_last) begin
          if (bit_idx == LAST_BIT) begin
            next_state = S_END_LOW;
          end else begin
            bit_idx_nxt = bit_idx + BIT_W'(1);
            next_state  = S_BIT_LOW;
          end
        end
      end
      S_END_LOW: begin
        if (cnt == LAST_ELOW) begin
          next_state = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase

    // Clearing enable mid-transaction drops straight back to idle.
    if (busy && !enable) begin
      next_state  = S_IDLE;
      load_shadow = 1'b0;
      frame_done  = 1'b0;
    end

    if (next_state != state) cnt_nxt = '0;

    drive_nxt = (next_state == S_RESP_LOW) || (next_state == S_BIT_LOW) ||
                (next_state == S_END_LOW);
  end

  // State, counters, frame shadow and registered pad drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shadow      <= '0;
      frame_count <= '0;
      drive_low   <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      drive_low <= drive_nxt;
      if (load_shadow) shadow <= {hum_int, hum_dec, temp_int, temp_dec, checksum};
      if (frame_done)  frame_count <= frame_count + 8'd1;
    end
  end

endmodule
